serial_pattern_tx: RTL
======================

Name: serial_pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit stream consumed by the team's 011/100 sequence detector. On a start request it serializes a selected 3-bit marker pattern (011 or 100) MSB first, repeated N times, with optional idle gap bits between frames. It sits upstream of the detector and serves as the stimulus/traffic source in the serial-link block set. All state updates on the rising edge of ck, so s is stable at the detector's falling-edge sample.

Parameters:
CNT_W, 4, width of repeat-count input
GAP_BITS, 1, idle bit-times inserted between consecutive frames (0 = back-to-back)
IDLE_BIT, 1'b0, level driven on s when not sending a pattern bit

Ports:
ck  input  1  clock; all registers update on its rising edge
rs  input  1  asynchronous, active-low reset (rs=0 resets immediately)
start  input  1  request; sampled only in IDLE
sel  input  1  pattern select: 0 = 011, 1 = 100
cnt  input  CNT_W  number of frames to send; sampled with start
abort  input  1  synchronous abort of an active transfer
s  output  1  serial data out, registered
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset (rs=0, async): state=IDLE, s=IDLE_BIT, busy=0, done=0, bit index=2, frame counter=0, gap counter=0.
- States: IDLE, SEND, GAP, DONE.
- IDLE: s=IDLE_BIT, busy=0. On the edge where start=1:
  - cnt!=0: latch sel and cnt, s<=pattern[2], bit index<=1, busy<=1, go SEND. The first bit is valid for the full cycle after the sampling edge.
  - cnt==0: no bits sent, go DONE (done pulses once).
- SEND: each edge drives the next pattern bit MSB first; every bit holds exactly one ck period. After bit 0's period, decrement remaining frames.
  - remaining>0 and GAP_BITS>0: go GAP.
  - remaining>0 and GAP_BITS=0: drive pattern[2] of the next frame on the same edge (no bubble).
  - remaining==0: go DONE.
- GAP: s=IDLE_BIT for exactly GAP_BITS cycles, then s<=pattern[2], go SEND.
- DONE: s=IDLE_BIT, busy=0, done=1 for exactly one cycle, then IDLE. A start seen during DONE is ignored; start is accepted from the next IDLE cycle.
- busy is high for exactly 3*N + GAP_BITS*(N-1) cycles, from the first bit through the last bit.
- start while busy: ignored. sel and cnt changes mid-transfer have no effect (latched values are used).
- abort=1 in SEND or GAP: next edge gives IDLE, s=IDLE_BIT, busy=0, no done pulse. abort in IDLE or DONE has no effect. If start and abort are both 1 in IDLE, start wins.
- Reset mid-transfer: immediate return to reset values; no partial frame is resumed.
- Frame counter is CNT_W bits. Maximum N = 2^CNT_W-1 (15 by default); there is no wrap.

Test Plan:
- Reset: hold rs=0 with start=1 -> s=0, busy=0, done=0; release rs -> first frame starts on the next rising edge with start=1.
- sel=0, cnt=2, GAP_BITS=1 -> s sequence 0,1,1,0,0,1,1 over 7 cycles with busy=1 throughout, then done=1 for 1 cycle and s=0.
- sel=1, cnt=3, GAP_BITS=0 -> s = 1,0,0,1,0,0,1,0,0 back-to-back, busy for 9 cycles, then a single done pulse.
- cnt=0 with start=1 -> s stays 0, busy stays 0, done=1 for exactly one cycle.
- sel=0, cnt=4: pulse start mid-transfer with sel=1 -> ignored, all frames are 011; assert abort on the 5th bit -> s=0 and busy=0 on the next edge, no done.
- Assert rs=0 asynchronously mid-bit during a sel=1, cnt=5 transfer -> s=0 and busy=0 immediately; after release, a new start (sel=0, cnt=1) gives 0,1,1 then done.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial marker-pattern source for the 011/100 sequence detector.
// Sends a 3-bit pattern MSB first, N times, with optional idle gap bits between frames.
module serial_pattern_tx #(
  parameter int   CNT_W    = 4,
  parameter int   GAP_BITS = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             start,
  input  logic             sel,
  input  logic [CNT_W-1:0] cnt,
  input  logic             abort,
  output logic             s,
  output logic             busy,
  output logic             done
);

  // The gap counter only has to hold GAP_BITS-1, so it never needs more than clog2(GAP_BITS) bits
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       bit_q, bit_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sel_q, sel_d;
  logic [3:0]       pat_q;
  logic [2:0]       new_pat;
  logic [CNT_W-1:0] frames_dec;

  assign s    = s_q;
  assign busy = busy_q;
  assign done = done_q;

  // Bit 3 of pat_q is padding so a wrapped bit index never selects out of range
  assign pat_q      = {1'b0, (sel_q ? 3'b100 : 3'b011)};
  assign new_pat    = sel ? 3'b100 : 3'b011;
  assign frames_dec = frames_q - CNT_W'(1);

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state_q  <= IDLE;
      s_q      <= IDLE_BIT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bit_q    <= 2'd2;
      frames_q <= '0;
      gap_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      sel_q    <= sel_d;
    end
  end

  // bit_q is the index of the next bit to drive; it wraps to 3 once bit 0 is on the line
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bit_d    = bit_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    sel_d    = sel_q;

    case (state_q)
      IDLE: begin
        s_d    = IDLE_BIT;
        busy_d = 1'b0;
        if (start) begin
          if (cnt != '0) begin
            sel_d    = sel;
            frames_d = cnt;
            s_d      = new_pat[2];
            bit_d    = 2'd1;
            busy_d   = 1'b1;
            state_d  = SEND;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      SEND: begin
        if (abort) begin
          s_d     = IDLE_BIT;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bit_q != 2'd3) begin
          s_d   = pat_q[bit_q];
          bit_d = bit_q - 2'd1;
        end else begin
          frames_d = frames_dec;
          if (frames_dec == '0) begin
            s_d     = IDLE_BIT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (GAP_BITS > 0) begin
            s_d     = IDLE_BIT;
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            s_d   = pat_q[2];
            bit_d = 2'd1;
          end
        end
      end

      GAP: begin
        if (abort) begin
          s_d     = IDLE_BIT;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (gap_q == '0) begin
          s_d     = pat_q[2];
          bit_d   = 2'd1;
          state_d = SEND;
        end else begin
          s_d   = IDLE_BIT;
          gap_d = gap_q - GAP_W'(1);
        end
      end

      DONE: begin
        s_d     = IDLE_BIT;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        s_d     = IDLE_BIT;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
